// File: rtl/regfile_ext.sv
// Two-read/one-write register file with read-modify-write ops, same-cycle
// write bypass, per-entry dirty flags and a background clear sweep.
module regfile_ext #(
    parameter int  WIDTH    = 8,
    parameter int  DEPTH    = 8,
    parameter bit  ZERO_REG = 1'b0,
    parameter bit  BYPASS   = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    dest,
    input  logic [WIDTH-1:0] dataD,
    input  logic [AW-1:0]    srcA,
    input  logic [AW-1:0]    srcB,
    output logic [WIDTH-1:0] dataA,
    output logic [WIDTH-1:0] dataB,
    input  logic             clr_start,
    output logic             busy,
    output logic [DEPTH-1:0] dirty
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    // Add wraps modulo 2^WIDTH by truncation to the result width.
    function automatic logic [WIDTH-1:0] rmw(input logic [1:0]       f_op,
                                             input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] d);
        case (f_op)
            OP_WR:   rmw = d;
            OP_ADD:  rmw = old + d;
            OP_OR:   rmw = old | d;
            OP_ANDN: rmw = old & ~d;
            default: rmw = d;
        endcase
    endfunction

    // Addresses that map to a real, writable/readable entry.
    function automatic logic live_addr(input logic [AW-1:0] a);
        live_addr = (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] dirty_q, dirty_d;
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;

    logic             wr_ok;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] new_val;

    assign busy    = (state_q == ST_SWEEP);
    assign dirty   = dirty_q;
    assign wr_ok   = ld && !busy && live_addr(dest);
    assign old_val = live_addr(dest) ? mem_q[dest] : '0;
    assign new_val = rmw(op, old_val, dataD);

    always_comb begin
        dataA = live_addr(srcA) ? mem_q[srcA] : '0;
        if (BYPASS && wr_ok && (srcA == dest)) begin
            dataA = new_val;
        end
    end

    always_comb begin
        dataB = live_addr(srcB) ? mem_q[srcB] : '0;
        if (BYPASS && wr_ok && (srcB == dest)) begin
            dataB = new_val;
        end
    end

    // Writes are refused while sweeping, so the two updates never collide.
    always_comb begin
        mem_d   = mem_q;
        dirty_d = dirty_q;
        state_d = state_q;
        idx_d   = idx_q;
        if (wr_ok) begin
            mem_d[dest]   = new_val;
            dirty_d[dest] = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            default: begin
                mem_d[idx_q]   = '0;
                dirty_d[idx_q] = 1'b0;
                if (int'(idx_q) == DEPTH - 1) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            dirty_q <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            dirty_q <= dirty_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_ext.sv
// Bench for regfile_ext: three configurations share one directed stimulus and
// are checked every cycle against an array/countdown model plus literal values.
module tb_regfile_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ld, clr_start;
    logic [1:0]  op;
    logic [2:0]  dest, srcA, srcB;
    logic [11:0] dataD;

    logic [7:0]  da0, db0, da1, db1;
    logic [11:0] da2, db2;
    logic        busy0, busy1, busy2;
    logic [7:0]  dirty0, dirty1;
    logic [4:0]  dirty2;

    regfile_ext #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u0 (
        .clk(clk), .reset(reset), .ld(ld), .op(op), .dest(dest), .dataD(dataD[7:0]),
        .srcA(srcA), .srcB(srcB), .dataA(da0), .dataB(db0),
        .clr_start(clr_start), .busy(busy0), .dirty(dirty0));

    regfile_ext #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
        .clk(clk), .reset(reset), .ld(ld), .op(op), .dest(dest), .dataD(dataD[7:0]),
        .srcA(srcA), .srcB(srcB), .dataA(da1), .dataB(db1),
        .clr_start(clr_start), .busy(busy1), .dirty(dirty1));

    regfile_ext #(.WIDTH(12), .DEPTH(5), .ZERO_REG(1'b0), .BYPASS(1'b1)) u2 (
        .clk(clk), .reset(reset), .ld(ld), .op(op), .dest(dest), .dataD(dataD),
        .srcA(srcA), .srcB(srcB), .dataA(da2), .dataB(db2),
        .clr_start(clr_start), .busy(busy2), .dirty(dirty2));

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    // Model: contents, dirty bits, and how many entries the sweep still has to clear.
    int cdep [3] = '{8, 8, 5};
    int cw   [3] = '{8, 8, 12};
    bit cz   [3] = '{1'b0, 1'b1, 1'b0};
    bit cb   [3] = '{1'b1, 1'b0, 1'b1};
    int mf   [3][8];
    bit md   [3][8];
    int left [3];

    task automatic check(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic bit accepted(input int i);
        return (ld == 1'b1) && (left[i] == 0) && (int'(dest) < cdep[i]) &&
               !(cz[i] && dest == 3'd0);
    endfunction

    function automatic int newval(input int i);
        int mask = (1 << cw[i]) - 1;
        int d    = int'(dataD) & mask;
        int old  = (int'(dest) < cdep[i]) ? mf[i][int'(dest)] : 0;
        case (op)
            2'b00:   return d;
            2'b01:   return (old + d) & mask;
            2'b10:   return old | d;
            default: return old & ~d & mask;
        endcase
    endfunction

    function automatic int exp_read(input int i, input int src);
        if (cb[i] && accepted(i) && src == int'(dest)) return newval(i);
        if (src >= cdep[i] || (cz[i] && src == 0)) return 0;
        return mf[i][src];
    endfunction

    function automatic int exp_dirty(input int i);
        int r = 0;
        for (int k = 0; k < cdep[i]; k++) if (md[i][k]) r |= (1 << k);
        return r;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                for (int k = 0; k < 8; k++) begin
                    mf[i][k] = 0;
                    md[i][k] = 1'b0;
                end
                left[i] = 0;
            end else begin
                bit acc = accepted(i);
                int nv  = newval(i);
                if (left[i] > 0) begin
                    mf[i][cdep[i] - left[i]] = 0;
                    md[i][cdep[i] - left[i]] = 1'b0;
                    left[i]--;
                end else if (clr_start) begin
                    left[i] = cdep[i];
                end
                if (acc) begin
                    mf[i][int'(dest)] = nv;
                    md[i][int'(dest)] = 1'b1;
                end
            end
        end
    endtask

    function automatic int got_a(input int i);
        return (i == 0) ? int'(da0) : (i == 1) ? int'(da1) : int'(da2);
    endfunction
    function automatic int got_b(input int i);
        return (i == 0) ? int'(db0) : (i == 1) ? int'(db1) : int'(db2);
    endfunction
    function automatic int got_busy(input int i);
        return (i == 0) ? int'(busy0) : (i == 1) ? int'(busy1) : int'(busy2);
    endfunction
    function automatic int got_dirty(input int i);
        return (i == 0) ? int'(dirty0) : (i == 1) ? int'(dirty1) : int'(dirty2);
    endfunction

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d.dataA", i), got_a(i), exp_read(i, int'(srcA)));
                check($sformatf("u%0d.dataB", i), got_b(i), exp_read(i, int'(srcB)));
                check($sformatf("u%0d.busy", i), got_busy(i), (left[i] > 0) ? 1 : 0);
                check($sformatf("u%0d.dirty", i), got_dirty(i), exp_dirty(i));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] o, input int d, input int v);
        ld    = 1'b1;
        op    = o;
        dest  = d[2:0];
        dataD = v[11:0];
    endtask

    initial begin
        int nb0, nb2;
        reset = 1'b1; ld = 1'b0; op = 2'b00; dest = '0; dataD = '0;
        srcA = '0; srcB = '0; clr_start = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        #1;
        check("reset_dataA", int'(da0), 0);
        check("reset_busy", int'(busy0), 0);
        check("reset_dirty", int'(dirty0), 0);

        // Plain write with same-cycle bypass
        srcA = 3'd3;
        wr(2'b00, 3, 'hA5);
        #1;
        check("wr_bypass_u0", int'(da0), 'hA5);
        check("wr_nobypass_u1", int'(da1), 0);
        tick();
        ld = 1'b0;
        #1;
        check("wr_after_u0", int'(da0), 'hA5);
        check("wr_dirty_u0", int'(dirty0), 'h08);
        check("wr_after_u1", int'(da1), 'hA5);

        // Read-modify-write chain
        srcA = 3'd2;
        wr(2'b00, 2, 'hFE);
        tick();
        wr(2'b01, 2, 'h03);
        #1;
        check("add_wrap_u0", int'(da0), 'h01);
        check("add_u2", int'(da2), 'h101);
        tick();
        wr(2'b10, 2, 'h80);
        #1;
        check("or_u0", int'(da0), 'h81);
        check("or_u2", int'(da2), 'h181);
        tick();
        wr(2'b11, 2, 'h01);
        #1;
        check("andn_u0", int'(da0), 'h80);
        check("andn_u2", int'(da2), 'h180);
        check("andn_old_u1", int'(da1), 'h81);
        tick();
        ld = 1'b0;
        #1;
        check("andn_after_u1", int'(da1), 'h80);

        // Hard-wired zero register and no-bypass read timing
        srcA = 3'd0;
        wr(2'b00, 0, 'h55);
        #1;
        check("zero_bypass_u1", int'(da1), 0);
        check("zero_bypass_u0", int'(da0), 'h55);
        tick();
        ld = 1'b0;
        #1;
        check("zero_read_u1", int'(da1), 0);
        check("zero_dirty_u1", int'(dirty1), 'h0C);
        srcB = 3'd1;
        wr(2'b00, 1, 'h33);
        #1;
        check("nobyp_old_u1", int'(db1), 0);
        check("byp_new_u0", int'(db0), 'h33);
        tick();
        ld = 1'b0;
        #1;
        check("nobyp_new_u1", int'(db1), 'h33);

        // Full sweep: busy length, per-entry clear timing, ignored ld/clr_start
        for (int k = 0; k < 8; k++) begin
            wr(2'b00, k, 'h10 + k);
            tick();
        end
        ld = 1'b0;
        srcA = 3'd4;
        srcB = 3'd0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        nb0 = 0;
        nb2 = 0;
        for (int j = 0; j < 12; j++) begin
            if (j < 3) wr(2'b00, 5, 'h77);
            else ld = 1'b0;
            clr_start = (j == 2);
            #1;
            if (busy0) nb0++;
            if (busy2) nb2++;
            check($sformatf("sweep_e4_j%0d", j), int'(da0), (j >= 5) ? 0 : 'h14);
            tick();
        end
        ld = 1'b0;
        clr_start = 1'b0;
        #1;
        check("sweep_busy_cycles_u0", nb0, 8);
        check("sweep_busy_cycles_u2", nb2, 5);
        check("sweep_dirty_u0", int'(dirty0), 0);
        check("sweep_dirty_u1", int'(dirty1), 0);
        check("sweep_dirty_u2", int'(dirty2), 0);

        // Reset in the middle of a sweep, then a fresh sweep starts at entry 0
        for (int k = 0; k < 8; k++) begin
            wr(2'b00, k, 'h20 + k);
            tick();
        end
        ld = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        srcA = 3'd7;
        srcB = 3'd5;
        #1;
        check("rst_sweep_busy", int'(busy0), 0);
        check("rst_sweep_dirty", int'(dirty0), 0);
        check("rst_sweep_e7", int'(da0), 0);
        check("rst_sweep_e5", int'(db0), 0);
        for (int k = 0; k < 8; k++) begin
            wr(2'b00, k, 'h30 + k);
            tick();
        end
        ld = 1'b0;
        srcA = 3'd0;
        srcB = 3'd3;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        #1;
        check("restart_e0", int'(da0), 0);
        check("restart_e3", int'(db0), 'h33);
        check("restart_busy", int'(busy0), 1);
        repeat (10) tick();

        // Out-of-range addresses on the 5-entry file
        srcA = 3'd6;
        srcB = 3'd7;
        wr(2'b00, 6, 'h123);
        #1;
        check("oor_bypass_u2", int'(da2), 0);
        check("oor_src7_u2", int'(db2), 0);
        check("oor_bypass_u0", int'(da0), 'h23);
        tick();
        ld = 1'b0;
        #1;
        check("oor_read_u2", int'(da2), 0);
        check("oor_dirty_u2", int'(dirty2), 0);
        check("oor_read_u0", int'(da0), 'h23);
        check("oor_dirty_u0", int'(dirty0), 'h40);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_ext.md
# regfile_ext

Parametrised register file for the game datapath, the next generation of the 8x8 two-read/one-write file. It adds configurable width and depth, an optional hard-wired zero register, and read-modify-write operations (add, set bits, clear bits) for neighbour counts and cell flags. It also provides write-to-read bypass, per-entry dirty flags, and a background clear sequencer so a new board can be wiped without a global reset. It sits between the game controller FSM and the ALU/display logic.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of two)
- AW, $clog2(DEPTH), address width (localparam, not overridable)
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = read ports forward the same-cycle write result
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- ld  input  1  write/RMW request this cycle
- op  input  2  00 write dataD, 01 add dataD, 10 OR dataD, 11 AND ~dataD
- dest  input  AW  target entry
- dataD  input  WIDTH  write operand
- srcA  input  AW  read address A
- srcB  input  AW  read address B
- dataA  output  WIDTH  read data A (combinational)
- dataB  output  WIDTH  read data B (combinational)
- clr_start  input  1  start background clear sweep
- busy  output  1  clear sweep in progress
- dirty  output  DEPTH  bit i set = entry i written since last clear/reset

## Operation
- Accepted write: ld=1 and busy=0 and dest<DEPTH and not (ZERO_REG=1 and dest=0). All other ld cycles are no-ops, with no effect on data or dirty.
- The new value computed from the current stored value old=file[dest]:
  - op 00: dataD
  - op 01: (old+dataD) mod 2^WIDTH, wraps silently
  - op 10: old|dataD
  - op 11: old&~dataD
- On an accepted write, file[dest] and dirty[dest] are set at the next edge.
- Reads are combinational: dataX=file[srcX]. Reads return 0 when srcX>=DEPTH, or when ZERO_REG=1 and srcX=0.
- BYPASS=1: if an accepted write targets srcX this cycle, dataX equals the new value. BYPASS=0: dataX shows the old value until the edge.
- Clear FSM with states IDLE and SWEEP, plus an index register idx:
  - IDLE: clr_start=1 moves to SWEEP with idx=0; busy=1 from the next cycle.
  - SWEEP: at each edge, file[idx] and dirty[idx] are set to 0 and idx increments. After idx=DEPTH-1 is cleared, the FSM returns to IDLE.
  - busy is high for exactly DEPTH cycles.
  - clr_start is ignored while busy.
- ld and clr_start in the same IDLE cycle: the write is accepted, then the sweep clears that entry anyway.
- During SWEEP, reads return stored contents; entries not yet swept keep their old values.
- reset (any state, including mid-sweep): all entries 0, dirty 0, FSM IDLE, idx 0, busy 0. reset has priority over ld and clr_start.

## Timing
- Write and RMW: 1-cycle latency. The value is visible on the reads the cycle after the edge, or the same cycle via bypass.
- clr_start at edge n: busy=1 in cycles n+1..n+DEPTH. Entry k is cleared at edge n+1+k. busy=0 and all entries zero after edge n+DEPTH.
- Output reset values: dataA and dataB 0 (all entries 0), busy 0, dirty 0.
- No combinational path from clr_start to any output.
- The bypass path is combinational from ld/op/dest/dataD/srcX to dataX.

## Test plan
- Reset, then write op00 dest=3 dataD=0xA5 with srcA=3 -> dataA=0xA5 in the same cycle (bypass) and after the edge; dirty=0x08.
- file[2]=0xFE, then op01 dataD=0x03 -> file[2]=0x01 (wrap). Then op10 dataD=0x80 -> 0x81. Then op11 dataD=0x01 -> 0x80.
- ZERO_REG=1: write 0x55 to dest=0 -> dataA(src=0)=0, dirty[0]=0. BYPASS=0: write 0x33 to dest=1 with srcB=1 -> dataB shows the old value until the edge, 0x33 after.
- Fill all 8 entries and pulse clr_start -> busy high exactly 8 cycles. Entry k reads 0 only after edge k+1. ld during busy is ignored. All entries 0 and dirty=0 at the end.
- Assert reset at sweep cycle 3 -> busy=0 next cycle, all entries and dirty 0. A later clr_start restarts the sweep from idx 0.
- DEPTH=5, WIDTH=12: write to dest=6 -> ignored; srcA=7 -> dataA=0. A full sweep takes 5 busy cycles.
